// File: rtl/io_pattern_bank.sv
// rtl/io_pattern_bank.sv - configurable header-pin driver: static, divider, PWM and one-shot channels
// Also owns the shared free-running 32-bit tick counter.
module io_pattern_bank #(
    parameter int NCH   = 14,
    parameter int PWM_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_wr,
    input  logic [7:0]      cfg_sel,
    input  logic [31:0]     cfg_data,
    output logic [NCH-1:0]  pins,
    output logic [NCH-1:0]  pulse_active,
    output logic [31:0]     tick_cnt
);

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_DIV     = 2'd1;
    localparam logic [1:0] MODE_PWM     = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

    logic [31:0]      cnt_prev;
    logic [31:0]      tick;
    logic [31:0]      cfg   [NCH];
    logic [PWM_W-1:0] phase [NCH];
    logic [15:0]      plen  [NCH];
    logic [NCH-1:0]   hit;
    logic [NCH-1:0]   ch_tick;
    logic [NCH-1:0]   raw;

    // One-cycle strobe on every rising edge of each counter bit.
    assign tick = tick_cnt & ~cnt_prev;

    always_comb begin
        hit     = '0;
        ch_tick = '0;
        raw     = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i]     = cfg_wr && (cfg_sel == 8'(i));
            ch_tick[i] = tick[cfg[i][7:3]];
            case (cfg[i][1:0])
                MODE_STATIC:  raw[i] = cfg[i][8];
                MODE_DIV:     raw[i] = tick_cnt[cfg[i][7:3]];
                MODE_PWM:     raw[i] = (phase[i] < cfg[i][8 +: PWM_W]);
                default:      raw[i] = pulse_active[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt     <= '0;
            cnt_prev     <= '0;
            pins         <= '0;
            pulse_active <= '0;
            for (int i = 0; i < NCH; i++) begin
                cfg[i]   <= '0;
                phase[i] <= '0;
                plen[i]  <= '0;
            end
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
            cnt_prev <= tick_cnt;
            for (int i = 0; i < NCH; i++) begin
                pins[i] <= raw[i] ^ cfg[i][2];
                // A write replaces all channel state and swallows a coincident tick.
                if (hit[i]) begin
                    cfg[i]   <= cfg_data;
                    phase[i] <= '0;
                    if (cfg_data[1:0] == MODE_ONESHOT) begin
                        plen[i]         <= cfg_data[31:16];
                        pulse_active[i] <= |cfg_data[31:16];
                    end else begin
                        plen[i]         <= '0;
                        pulse_active[i] <= 1'b0;
                    end
                end else if (ch_tick[i]) begin
                    if (cfg[i][1:0] == MODE_PWM)
                        phase[i] <= phase[i] + PWM_W'(1);
                    if (cfg[i][1:0] == MODE_ONESHOT && pulse_active[i]) begin
                        plen[i] <= plen[i] - 16'd1;
                        if (plen[i] == 16'd1)
                            pulse_active[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_io_pattern_bank.sv
// tb/tb_io_pattern_bank.sv - directed self-checking bench for io_pattern_bank
module tb_io_pattern_bank;

    localparam int NCH = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_wr;
    logic [7:0]      cfg_sel;
    logic [31:0]     cfg_data;
    logic [NCH-1:0]  pins;
    logic [NCH-1:0]  pulse_active;
    logic [31:0]     tick_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] m_cnt;

    io_pattern_bank #(.NCH(NCH), .PWM_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr       (cfg_wr),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .pins         (pins),
        .pulse_active (pulse_active),
        .tick_cnt     (tick_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= '0;
        else     m_cnt <= m_cnt + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] sel, input logic [31:0] data);
        cfg_wr   = 1'b1;
        cfg_sel  = sel;
        cfg_data = data;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    // Write on an edge that carries tick[0] (counter odd just before the edge).
    task automatic wr_al(input logic [7:0] sel, input logic [31:0] data);
        for (int k = 0; k < 4 && tick_cnt[0] !== 1'b1; k++) @(negedge clk);
        chk("align", 32'(tick_cnt[0]), 32'd1);
        wr(sel, data);
    endtask

    task automatic count_active5(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (pulse_active[5] !== 1'b1) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [31:0] prev;
        rst = 1'b1; cfg_wr = 1'b0; cfg_sel = '0; cfg_data = '0;
        @(negedge clk);
        chk("reset_pins", 32'(pins), 32'd0);
        chk("reset_pa", 32'(pulse_active), 32'd0);
        chk("reset_cnt", tick_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("cnt_first", tick_cnt, 32'd1);

        // Static level, invert, out-of-range select
        wr(8'd3, 32'h0000_0100);
        chk("static_lat_e", 32'(pins[3]), 32'd0);
        @(negedge clk);
        chk("static_hi", 32'(pins[3]), 32'd1);
        wr(8'd3, 32'h0000_0104);
        @(negedge clk);
        chk("static_inv", 32'(pins[3]), 32'd0);
        wr(8'(NCH), 32'h0000_0100);
        wr(8'd255, 32'h0003_0003);
        @(negedge clk);
        chk("oor_pins", 32'(pins), 32'd0);
        chk("oor_pa", 32'(pulse_active), 32'd0);

        // Divider tap 2
        wr(8'd0, 32'h0000_0011);
        @(negedge clk);
        chk("div_cnt", tick_cnt, m_cnt);
        for (int k = 0; k < 16; k++) begin
            prev = (m_cnt - 32'd1) >> 2;
            chk("div_pin", 32'(pins[0]), {31'd0, prev[0]});
            @(negedge clk);
        end

        // PWM tap 0, duty 0x40 then 0
        wr(8'd1, 32'h0000_4002);
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 512; k++) begin
            if (pins[1]) n++;
            @(negedge clk);
        end
        chk("pwm_duty40", 32'(n), 32'd128);
        wr(8'd1, 32'h0000_0002);
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            if (pins[1]) n++;
            @(negedge clk);
        end
        chk("pwm_duty0", 32'(n), 32'd0);

        // One-shot tap 0, length 3
        wr_al(8'd5, 32'h0003_0003);
        chk("os_set_e", 32'(pulse_active[5]), 32'd1);
        @(negedge clk);
        chk("os_pin", 32'(pins[5]), 32'd1);
        wr_al(8'd5, 32'h0003_0003);
        count_active5(n);
        chk("os_restart_len", 32'(n), 32'd6);
        @(negedge clk);
        chk("os_pin_idle", 32'(pins[5]), 32'd0);
        wr_al(8'd5, 32'h0003_0003);
        count_active5(n);
        chk("os_len", 32'(n), 32'd6);
        wr_al(8'd5, 32'h0003_0003);
        @(negedge clk);
        wr(8'd5, 32'h0000_0003);
        chk("os_abort", 32'(pulse_active[5]), 32'd0);
        wr(8'd5, 32'h0003_0003);
        wr(8'd5, 32'h0000_0100);
        chk("os_leave", 32'(pulse_active[5]), 32'd0);

        // Write coinciding with a PWM tick: duty 1 shows phase 0 for two clocks
        wr_al(8'd2, 32'h0000_0102);
        @(negedge clk);
        chk("pwm_wr_tick_1", 32'(pins[2]), 32'd1);
        @(negedge clk);
        chk("pwm_wr_tick_2", 32'(pins[2]), 32'd1);
        @(negedge clk);
        chk("pwm_wr_tick_3", 32'(pins[2]), 32'd0);

        // Asynchronous reset mid-pulse
        wr(8'd3, 32'h0000_0100);
        wr(8'd5, 32'hFFFF_0003);
        @(negedge clk);
        chk("pre_rst_pin", 32'(pins[3]), 32'd1);
        chk("pre_rst_pa", 32'(pulse_active[5]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pins", 32'(pins), 32'd0);
        chk("arst_pa", 32'(pulse_active), 32'd0);
        chk("arst_cnt", tick_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("post_rst_cnt", tick_cnt, 32'(k));
        end
        chk("post_rst_pins", 32'(pins), 32'd0);
        chk("post_rst_pa", 32'(pulse_active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
